// File: rtl/haze_stream_framer.sv
// Framer: tags pixel beats with TUSER/TLAST and sequences passes; optional host-TLAST check under FRAMER_TLAST_CHECK_EN.
// Latency: one cycle from S handshake to valid on M.
// Backpressure: output register plus one skid register; registered TREADY drops once the skid register fills.
module haze_stream_framer #(
   parameter int DATA_W     = 32,
   parameter int IMG_W      = 512,
   parameter int IMG_H      = 512,
   parameter int NUM_PASSES = 2,
   localparam int PW        = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              enable,
   input  logic [DATA_W-1:0] S_AXIS_TDATA,
   input  logic              S_AXIS_TVALID,
   input  logic              S_AXIS_TLAST,
   output logic              S_AXIS_TREADY,
   output logic [DATA_W-1:0] M_AXIS_TDATA,
   output logic              M_AXIS_TVALID,
   input  logic              M_AXIS_TREADY,
   output logic              M_AXIS_TUSER,
   output logic              M_AXIS_TLAST,
   output logic [PW-1:0]     pass_idx,
   output logic              pass_done,
   output logic              frame_done,
   output logic              tlast_err
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] dat;
      logic              user;
      logic              last;
      logic              eop;
      logic              eof;
      logic [PW-1:0]     pass;
   } beat_t;

   state_t        state, state_nxt;
   logic          s_rdy_q;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [PW-1:0] pass;
   beat_t         in_beat, out_beat, skid_beat;
   logic          out_vld, skid_vld, skid_vld_nxt;
   logic          s_hs, m_hs;

   assign s_hs = S_AXIS_TVALID & s_rdy_q;
   assign m_hs = out_vld & M_AXIS_TREADY;

   // Tags are computed from the counters at input time and travel with the data.
   always_comb begin
      in_beat      = '0;
      in_beat.dat  = S_AXIS_TDATA;
      in_beat.user = (col == '0) && (row == '0);
      in_beat.last = (col == COL_LAST);
      in_beat.eop  = (col == COL_LAST) && (row == ROW_LAST);
      in_beat.eof  = (col == COL_LAST) && (row == ROW_LAST) && (pass == PASS_LAST);
      in_beat.pass = pass;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable)  state_nxt = RUN;
         RUN:     if (!enable) state_nxt = HOLD;
         HOLD:    if (enable)  state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // The skid register only fills when a beat arrives while the output is stalled.
   always_comb begin
      skid_vld_nxt = skid_vld;
      if (m_hs && skid_vld)
         skid_vld_nxt = 1'b0;
      else if (!m_hs && s_hs && out_vld)
         skid_vld_nxt = 1'b1;
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state   <= IDLE;
         s_rdy_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         s_rdy_q <= (state_nxt == RUN) && !skid_vld_nxt;
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         col  <= '0;
         row  <= '0;
         pass <= '0;
      end else if (s_hs) begin
         if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
               row  <= '0;
               pass <= (pass == PASS_LAST) ? '0 : pass + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         out_vld   <= 1'b0;
         out_beat  <= '0;
         skid_vld  <= 1'b0;
         skid_beat <= '0;
      end else begin
         skid_vld <= skid_vld_nxt;
         if (m_hs) begin
            if (skid_vld)
               out_beat <= skid_beat;
            else if (s_hs)
               out_beat <= in_beat;
            out_vld <= skid_vld | s_hs;
         end else if (s_hs) begin
            if (out_vld) begin
               skid_beat <= in_beat;
            end else begin
               out_beat <= in_beat;
               out_vld  <= 1'b1;
            end
         end
      end
   end

   assign S_AXIS_TREADY = s_rdy_q;
   assign M_AXIS_TVALID = out_vld;
   assign M_AXIS_TDATA  = out_beat.dat;
   assign M_AXIS_TUSER  = out_beat.user;
   assign M_AXIS_TLAST  = out_beat.last;
   assign pass_idx      = out_beat.pass;
   assign pass_done     = m_hs & out_beat.eop;
   assign frame_done    = m_hs & out_beat.eof;

`ifdef FRAMER_TLAST_CHECK_EN
   logic err_q;

   always_ff @(posedge ACLK) begin
      if (!ARESETn)
         err_q <= 1'b0;
      else if (s_hs && (S_AXIS_TLAST != in_beat.last))
         err_q <= 1'b1;
   end

   assign tlast_err = err_q;
`else
   logic unused_tlast;
   assign unused_tlast = S_AXIS_TLAST;
   assign tlast_err    = 1'b0;
`endif

endmodule

// File: tb/tb_haze_stream_framer.sv
// Scoreboard bench for haze_stream_framer: random data and stall patterns against a beat-index model.
module tb_haze_stream_framer;

   localparam int W = 4;
   localparam int H = 2;
   localparam int P = 2;
`ifdef FRAMER_TLAST_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      logic [31:0] d;
      bit          user;
      bit          last;
      bit          pdone;
      bit          fdone;
      int          pass;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0, s_vld = 1'b0, s_last = 1'b0, m_rdy = 1'b1;
   logic [31:0] s_dat = '0;
   logic        s_rdy, m_vld, m_user, m_last, pass_done, frame_done, tlast_err;
   logic [31:0] m_dat;
   logic [0:0]  pass_idx;

   logic        en1 = 1'b0, s_vld1 = 1'b0, s_last1 = 1'b0, m_rdy1 = 1'b1;
   logic [31:0] s_dat1 = '0;
   logic        s_rdy1, m_vld1, m_user1, m_last1, pass_done1, frame_done1, tlast_err1;
   logic [31:0] m_dat1;
   logic [0:0]  pass_idx1;

   int   errors = 0, checks = 0;
   exp_t sb[$], sb1[$];
   int   pushed = 0, popped = 0, k = 0, k1 = 0, mode = 0, cyc = 0;
   bit   err_model = 1'b0;

   haze_stream_framer #(.DATA_W(32), .IMG_W(W), .IMG_H(H), .NUM_PASSES(P)) u_dut (
      .ACLK(clk), .ARESETn(rstn), .enable(en),
      .S_AXIS_TDATA(s_dat), .S_AXIS_TVALID(s_vld), .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_rdy),
      .M_AXIS_TDATA(m_dat), .M_AXIS_TVALID(m_vld), .M_AXIS_TREADY(m_rdy),
      .M_AXIS_TUSER(m_user), .M_AXIS_TLAST(m_last), .pass_idx(pass_idx),
      .pass_done(pass_done), .frame_done(frame_done), .tlast_err(tlast_err)
   );

   haze_stream_framer #(.DATA_W(32), .IMG_W(2), .IMG_H(1), .NUM_PASSES(1)) u_dut1 (
      .ACLK(clk), .ARESETn(rstn), .enable(en1),
      .S_AXIS_TDATA(s_dat1), .S_AXIS_TVALID(s_vld1), .S_AXIS_TLAST(s_last1), .S_AXIS_TREADY(s_rdy1),
      .M_AXIS_TDATA(m_dat1), .M_AXIS_TVALID(m_vld1), .M_AXIS_TREADY(m_rdy1),
      .M_AXIS_TUSER(m_user1), .M_AXIS_TLAST(m_last1), .pass_idx(pass_idx1),
      .pass_done(pass_done1), .frame_done(frame_done1), .tlast_err(tlast_err1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected tags follow directly from the beat's position in the stream.
   function automatic exp_t model(input int idx, input logic [31:0] d, input int w, input int h, input int p);
      exp_t e;
      int   col, row;
      col     = idx % w;
      row     = (idx / w) % h;
      e.d     = d;
      e.pass  = (idx / (w * h)) % p;
      e.user  = (col == 0) && (row == 0);
      e.last  = (col == w - 1);
      e.pdone = e.last && (row == h - 1);
      e.fdone = e.pdone && (e.pass == p - 1);
      return e;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            1:       m_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       m_rdy = 1'($urandom_range(0, 1));
            default: m_rdy = 1'b1;
         endcase
         cyc++;
      end
   end

   // Beats held inside the DUT never exceed two, and TREADY is low whenever both are held.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rstn && (pushed - popped) >= 2) begin
            chk("occupancy_max", pushed - popped, 2);
            chk("s_rdy_while_skid_full", s_rdy, 0);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rstn && m_vld && m_rdy) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %h with nothing expected", m_dat);
         end else begin
            e = sb.pop_front();
            popped++;
            chk("tdata", m_dat, e.d);
            chk("tuser", m_user, e.user);
            chk("tlast", m_last, e.last);
            chk("pass_idx", pass_idx, e.pass);
            chk("pass_done", pass_done, e.pdone);
            chk("frame_done", frame_done, e.fdone);
         end
      end else if (rstn && m_vld) begin
         chk("pass_done_stalled", pass_done, 0);
         chk("frame_done_stalled", frame_done, 0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rstn && m_vld1 && m_rdy1) begin
         if (sb1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat1: got data %h with nothing expected", m_dat1);
         end else begin
            e = sb1.pop_front();
            chk("tdata1", m_dat1, e.d);
            chk("tuser1", m_user1, e.user);
            chk("tlast1", m_last1, e.last);
            chk("pass_idx1", pass_idx1, e.pass);
            chk("pass_done1", pass_done1, e.pdone);
            chk("frame_done1", frame_done1, e.fdone);
         end
      end
   end

   task automatic send(input bit bad_last, output int waits, output logic [31:0] d);
      exp_t e;
      d     = $urandom;
      e     = model(k, d, W, H, P);
      waits = 0;
      s_dat = d;
      s_last = e.last ^ bad_last;
      s_vld = 1'b1;
      @(negedge clk);
      while (!s_rdy && waits < 64) begin
         waits++;
         @(negedge clk);
      end
      if (!s_rdy) begin
         checks++;
         errors++;
         $display("FAIL s_accept_timeout: TREADY low for %0d cycles, required high", waits);
      end else begin
         sb.push_back(e);
         pushed++;
         k++;
         if (bad_last && CHK) err_model = 1'b1;
      end
      @(posedge clk);
      #1;
      s_vld = 1'b0;
      chk("tlast_err", tlast_err, err_model);
   endtask

   task automatic send1();
      logic [31:0] d;
      int          waits;
      d      = $urandom;
      waits  = 0;
      s_dat1 = d;
      s_last1 = (k1 % 2 == 1);
      s_vld1 = 1'b1;
      @(negedge clk);
      while (!s_rdy1 && waits < 64) begin
         waits++;
         @(negedge clk);
      end
      if (!s_rdy1) begin
         checks++;
         errors++;
         $display("FAIL s_accept_timeout1: TREADY low for %0d cycles, required high", waits);
      end else begin
         sb1.push_back(model(k1, d, 2, 1, 1));
         k1++;
      end
      @(posedge clk);
      #1;
      s_vld1 = 1'b0;
   endtask

   task automatic drain(input bit second);
      int n;
      n = 0;
      while ((second ? sb1.size() : sb.size()) != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(second ? "drain_empty1" : "drain_empty", second ? sb1.size() : sb.size(), 0);
   endtask

   task automatic do_reset();
      s_vld = 1'b0;
      rstn  = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      sb.delete();
      pushed    = 0;
      popped    = 0;
      k         = 0;
      err_model = 1'b0;
      chk("rst_s_rdy", s_rdy, 0);
      chk("rst_m_vld", m_vld, 0);
      chk("rst_m_dat", m_dat, 0);
      chk("rst_tuser", m_user, 0);
      chk("rst_tlast", m_last, 0);
      chk("rst_pass_idx", pass_idx, 0);
      chk("rst_pass_done", pass_done, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_tlast_err", tlast_err, 0);
   endtask

   initial begin
      int          w;
      logic [31:0] d;
      en   = 1'b1;
      mode = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Unstalled frame: full rate, one-cycle latency.
      for (int i = 0; i < 16; i++) begin
         send(1'b0, w, d);
         if (i > 0) chk("throughput_wait", w, 0);
         chk("latency_vld", m_vld, 1);
         chk("latency_dat", m_dat, d);
      end
      drain(1'b0);

      mode = 1;
      for (int i = 0; i < 16; i++) send(1'b0, w, d);
      drain(1'b0);

      mode = 2;
      for (int i = 0; i < 40; i++) send(1'b0, w, d);
      drain(1'b0);

      // Enable gap after beat 5.
      mode = 0;
      do_reset();
      for (int i = 0; i < 6; i++) send(1'b0, w, d);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i > 0) chk("s_rdy_hold", s_rdy, 0);
      end
      chk("drained_in_hold", m_vld, 0);
      @(posedge clk);
      #1;
      en = 1'b1;
      for (int i = 0; i < 10; i++) send(1'b0, w, d);
      drain(1'b0);

      // Reset mid-frame after beat 10.
      mode = 2;
      do_reset();
      for (int i = 0; i < 11; i++) send(1'b0, w, d);
      mode = 0;
      do_reset();
      for (int i = 0; i < 8; i++) send(1'b0, w, d);
      drain(1'b0);

      // Host TLAST wrong on beat 2.
      do_reset();
      for (int i = 0; i < 8; i++) send(i == 2, w, d);
      drain(1'b0);
      chk("tlast_err_sticky", tlast_err, CHK);

      // Single-pass, 2x1 image.
      en1 = 1'b1;
      for (int i = 0; i < 4; i++) send1();
      drain(1'b1);
      chk("tlast_err1", tlast_err1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
